// File: rtl/strela_seq_pkg.sv
// Shared types for the register-bus command sequencer: command opcodes,
// response error codes, FSM states, the queued command record and the
// default register-bus request/response structs.
package strela_seq_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_POLL  = 2'd2
    } seq_op_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_BUS     = 2'd1,
        ERR_TIMEOUT = 2'd2
    } seq_err_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2,
        ST_RESP  = 2'd3
    } seq_state_e;

    typedef struct packed {
        seq_op_e     op;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] mask;
    } seq_cmd_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } seq_reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } seq_reg_rsp_t;

    localparam logic [3:0] SEQ_WSTRB_ALL = 4'hF;

    // The reserved opcode behaves as a plain READ.
    function automatic seq_op_e decode_op(input logic [1:0] raw);
        case (raw)
            2'd0:    return OP_WRITE;
            2'd2:    return OP_POLL;
            default: return OP_READ;
        endcase
    endfunction

    function automatic logic poll_match(input logic [31:0] rdata,
                                        input logic [31:0] cmp,
                                        input logic [31:0] mask);
        return ((rdata & mask) == (cmp & mask));
    endfunction

endpackage

// File: rtl/strela_seq_cmd_fifo.sv
// Synchronous command FIFO. Pointers wrap modulo DEPTH (power of two);
// a separate occupancy counter drives registered full/empty flags.
// A push while full is dropped even if a pop happens in the same cycle.
module strela_seq_cmd_fifo
    import strela_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  seq_cmd_t                 data_i,
    input  logic                     pop_i,
    output seq_cmd_t                 data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    seq_cmd_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic [AW:0]     count_d;
    logic            full_q;
    logic            empty_q;
    logic            do_push;
    logic            do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is pure data and needs no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    // Pointers, occupancy and registered full/empty flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_C);
            empty_q <= (count_d == '0);
        end
    end

    assign data_o  = mem[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;

endmodule

// File: rtl/strela_reg_sequencer.sv
// Register-bus initiator: executes queued WRITE/READ/POLL commands in order
// against a CSR responder and returns one response per command.
// Optional build macro STRELA_SEQ_TIMEOUT_EN adds a poll try counter that
// ends a non-matching POLL with a timeout response after POLL_MAX_TRIES reads;
// without it a POLL retries until it matches.
module strela_reg_sequencer
    import strela_seq_pkg::*;
#(
    parameter type         reg_req_t      = seq_reg_req_t,
    parameter type         reg_rsp_t      = seq_reg_rsp_t,
    parameter int unsigned CMD_DEPTH      = 4,
    parameter int unsigned POLL_GAP       = 4,
    parameter int unsigned POLL_MAX_TRIES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_op_i,
    input  logic [7:0]  cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    input  logic [31:0] cmd_mask_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic [1:0]  rsp_err_o,
    output logic        busy_o,
    output reg_req_t    reg_req_o,
    input  reg_rsp_t    reg_rsp_i
);

    if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("CMD_DEPTH must be a power of two and at least 2");
    end
    if (POLL_MAX_TRIES < 1) begin : g_bad_tries
        $error("POLL_MAX_TRIES must be at least 1");
    end

    // POLL_GAP of 0 still leaves one dead cycle between reads.
    localparam int unsigned     GAP_W      = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;
    localparam int unsigned     GAP_LOAD_I = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_LOAD_I);

    seq_state_e                   state_q;
    seq_cmd_t                     push_cmd;
    seq_cmd_t                     fifo_head;
    seq_cmd_t                     cur_q;
    logic                         fifo_pop;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [$clog2(CMD_DEPTH):0]   fifo_count;
    reg_req_t                     req_q;
    logic [GAP_W-1:0]             gap_cnt_q;
    logic                         rsp_valid_q;
    logic [31:0]                  rsp_rdata_q;
    seq_err_e                     rsp_err_q;
    logic                         xfer_done;
    logic                         poll_miss;
    logic                         poll_timeout;
    logic [31:0]                  resp_rdata_d;
    seq_err_e                     resp_err_d;

    function automatic reg_req_t make_req(input seq_cmd_t c);
        reg_req_t r;
        r       = '0;
        r.addr  = {24'b0, c.addr};
        r.write = (c.op == OP_WRITE);
        r.wdata = c.wdata;
        r.wstrb = SEQ_WSTRB_ALL;
        r.valid = 1'b1;
        return r;
    endfunction

    // Reserved opcode is folded into READ before it is queued.
    always_comb begin
        push_cmd       = '0;
        push_cmd.op    = decode_op(cmd_op_i);
        push_cmd.addr  = cmd_addr_i;
        push_cmd.wdata = cmd_wdata_i;
        push_cmd.mask  = cmd_mask_i;
    end

    strela_seq_cmd_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (cmd_valid_i),
        .data_i  (push_cmd),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
    assign xfer_done = (state_q == ST_ISSUE) && reg_rsp_i.ready;
    assign poll_miss = xfer_done && !reg_rsp_i.error && (cur_q.op == OP_POLL)
                       && !poll_match(reg_rsp_i.rdata, cur_q.wdata, cur_q.mask);

`ifdef STRELA_SEQ_TIMEOUT_EN
    localparam int unsigned      TRY_W    = $clog2(POLL_MAX_TRIES + 1);
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(POLL_MAX_TRIES - 1);

    logic [TRY_W-1:0] try_cnt_q;

    // Failed poll reads of the current command; restarts with each new command.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            try_cnt_q <= '0;
        end else if (fifo_pop) begin
            try_cnt_q <= '0;
        end else if (poll_miss) begin
            try_cnt_q <= try_cnt_q + 1'b1;
        end
    end

    assign poll_timeout = (try_cnt_q == TRY_LAST);
`else
    assign poll_timeout = 1'b0;
`endif

    // Response payload for the transfer completing this cycle.
    always_comb begin
        resp_rdata_d = (cur_q.op == OP_WRITE) ? 32'h0 : reg_rsp_i.rdata;
        if (reg_rsp_i.error) begin
            resp_err_d = ERR_BUS;
        end else if (poll_miss) begin
            resp_err_d = ERR_TIMEOUT;
        end else begin
            resp_err_d = ERR_OK;
        end
    end

    // Current command is captured as it leaves the FIFO.
    always_ff @(posedge clk_i) begin
        if (fifo_pop) begin
            cur_q <= fifo_head;
        end
    end

    // Sequencer FSM with registered bus request and response outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            gap_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= ERR_OK;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        req_q   <= make_req(fifo_head);
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (xfer_done) begin
                        req_q <= '0;
                        if (poll_miss && !poll_timeout) begin
                            gap_cnt_q <= GAP_LOAD;
                            state_q   <= ST_GAP;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= resp_rdata_d;
                            rsp_err_q   <= resp_err_d;
                            state_q     <= ST_RESP;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == '0) begin
                        req_q   <= make_req(cur_q);
                        state_q <= ST_ISSUE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready_o = !fifo_full;
    assign reg_req_o   = req_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = (fifo_count != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_strela_reg_sequencer.sv
// Directed bench for strela_reg_sequencer with a small CSR responder model:
// 0x00/0x04 are writable words, 0x08 reads back their sum, 0x50 reports
// done_config on bit 1, and addresses >= 0x80 read as 0xC0000000 | addr.
`timescale 1ns/1ps
module tb_strela_reg_sequencer;
    import strela_seq_pkg::*;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'd0;
    logic [7:0]   cmd_addr = 8'd0;
    logic [31:0]  cmd_wdata = 32'd0;
    logic [31:0]  cmd_mask = 32'd0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [31:0]  rsp_rdata;
    logic [1:0]   rsp_err;
    logic         busy;
    seq_reg_req_t reg_req;
    seq_reg_rsp_t reg_rsp;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int wait_cfg = 0;
    int wait_cnt = 0;
    logic err_inject = 1'b0;
    logic done_config = 1'b0;
    logic [31:0] csr_mem [0:63];
    int acc_cyc[$];
    int push_cyc[$];

    always #5 clk = ~clk;

    strela_reg_sequencer #(
        .CMD_DEPTH      (4),
        .POLL_GAP       (4),
        .POLL_MAX_TRIES (8)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_addr_i  (cmd_addr),
        .cmd_wdata_i (cmd_wdata),
        .cmd_mask_i  (cmd_mask),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .busy_o      (busy),
        .reg_req_o   (reg_req),
        .reg_rsp_i   (reg_rsp)
    );

    // Responder: combinational ready after wait_cfg wait cycles
    always_comb begin
        reg_rsp       = '0;
        reg_rsp.ready = reg_req.valid && (wait_cnt >= wait_cfg);
        reg_rsp.error = reg_rsp.ready && err_inject;
        if (reg_req.addr[7:0] == 8'h08)
            reg_rsp.rdata = csr_mem[0] + csr_mem[1];
        else if (reg_req.addr[7:0] == 8'h50)
            reg_rsp.rdata = {30'b0, done_config, 1'b0};
        else if (reg_req.addr[7])
            reg_rsp.rdata = 32'hC000_0000 | reg_req.addr;
        else
            reg_rsp.rdata = csr_mem[reg_req.addr[7:2]];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reg_req.valid && !reg_rsp.ready) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (reg_req.valid && reg_rsp.ready) begin
            acc_cyc.push_back(cyc);
            if (reg_req.write) csr_mem[reg_req.addr[7:2]] <= reg_req.wdata;
        end
        if (cmd_valid && cmd_ready) push_cyc.push_back(cyc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [1:0] op, input logic [7:0] addr,
                             input logic [31:0] wdata, input logic [31:0] mask);
        cmd_op = op; cmd_addr = addr; cmd_wdata = wdata; cmd_mask = mask; cmd_valid = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        n_checks++; if (reg_req !== '0) begin n_fail++; $display("FAIL reset_reg_req: got %h want 0", reg_req); end
        tick(); tick();
        rst_ni = 1'b1;
        tick();
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_cmd_ready: got %b want 1", cmd_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b want 0", busy); end
        n_checks++; if (rsp_rdata !== 32'h0 || rsp_err !== 2'd0) begin n_fail++; $display("FAIL post_reset_rsp_data: got %h/%0d want 0/0", rsp_rdata, rsp_err); end
        n_checks++; if (reg_req !== '0) begin n_fail++; $display("FAIL post_reset_reg_req: got %h want 0", reg_req); end
    endtask

    task automatic test_csr_sequence();
        int n0 = acc_cyc.size();
        int p0 = push_cyc.size();
        logic [31:0] rd [3];
        logic [1:0]  er [3];
        int got = 0;
        int t = 0;
        rsp_ready = 1'b1;
        drive_cmd(2'd0, 8'h00, 32'd5, 32'd0); tick();
        drive_cmd(2'd0, 8'h04, 32'd7, 32'd0); tick();
        drive_cmd(2'd1, 8'h08, 32'd0, 32'd0); tick();
        cmd_valid = 1'b0;
        while (got < 3 && t < 60) begin
            if (rsp_valid) begin rd[got] = rsp_rdata; er[got] = rsp_err; got++; end
            tick(); t++;
        end
        n_checks++; if (got != 3) begin n_fail++; $display("FAIL seq_rsp_count: got %0d want 3", got); end
        if (got == 3) begin
            n_checks++; if (rd[0] !== 32'd0 || rd[1] !== 32'd0) begin n_fail++; $display("FAIL seq_write_rdata: got %h %h want 0 0", rd[0], rd[1]); end
            n_checks++; if (rd[2] !== 32'd12) begin n_fail++; $display("FAIL seq_read_rdata: got %0d want 12", rd[2]); end
            n_checks++; if (er[0] !== 2'd0 || er[1] !== 2'd0 || er[2] !== 2'd0) begin n_fail++; $display("FAIL seq_err: got %0d %0d %0d want 0 0 0", er[0], er[1], er[2]); end
        end
        n_checks++; if (acc_cyc.size() - n0 != 3) begin n_fail++; $display("FAIL seq_access_count: got %0d want 3", acc_cyc.size() - n0); end
        if (acc_cyc.size() - n0 == 3) begin
            n_checks++; if (acc_cyc[n0] - push_cyc[p0] != 2) begin n_fail++; $display("FAIL seq_latency: got %0d want 2", acc_cyc[n0] - push_cyc[p0]); end
            n_checks++; if (acc_cyc[n0+1] - acc_cyc[n0] != 3) begin n_fail++; $display("FAIL seq_spacing_1: got %0d want 3", acc_cyc[n0+1] - acc_cyc[n0]); end
            n_checks++; if (acc_cyc[n0+2] - acc_cyc[n0+1] != 3) begin n_fail++; $display("FAIL seq_spacing_2: got %0d want 3", acc_cyc[n0+2] - acc_cyc[n0+1]); end
        end
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL seq_busy_idle: got %b want 0", busy); end
    endtask

    task automatic test_poll();
        int n0 = acc_cyc.size();
        int t = 0;
        done_config = 1'b0;
        rsp_ready = 1'b1;
        drive_cmd(2'd2, 8'h50, 32'h2, 32'h2); tick();
        cmd_valid = 1'b0;
        while (acc_cyc.size() == n0 && t < 20) begin tick(); t++; end
        n_checks++; if (acc_cyc.size() == n0) begin n_fail++; $display("FAIL poll_first_read: got no bus read want one"); end
        repeat (20) tick();
        done_config = 1'b1;
        t = 0;
        while (!rsp_valid && t < 60) begin tick(); t++; end
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL poll_rsp_valid: got %b want 1", rsp_valid); end
        n_checks++; if (rsp_rdata !== 32'h2 || rsp_err !== 2'd0) begin n_fail++; $display("FAIL poll_rsp: got %h/%0d want 2/0", rsp_rdata, rsp_err); end
        n_checks++; if (acc_cyc.size() - n0 != 6) begin n_fail++; $display("FAIL poll_read_count: got %0d want 6", acc_cyc.size() - n0); end
        for (int i = n0 + 1; i < acc_cyc.size(); i++) begin
            n_checks++; if (acc_cyc[i] - acc_cyc[i-1] != 5) begin n_fail++; $display("FAIL poll_spacing_%0d: got %0d want 5", i - n0, acc_cyc[i] - acc_cyc[i-1]); end
        end
        tick();
        done_config = 1'b0;
    endtask

`ifdef STRELA_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int n0 = acc_cyc.size();
        int t = 0;
        done_config = 1'b0;
        rsp_ready = 1'b1;
        drive_cmd(2'd2, 8'h50, 32'h2, 32'h2); tick();
        cmd_valid = 1'b0;
        while (!rsp_valid && t < 200) begin tick(); t++; end
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL timeout_rsp_valid: got %b want 1", rsp_valid); end
        n_checks++; if (rsp_err !== 2'd2) begin n_fail++; $display("FAIL timeout_err: got %0d want 2", rsp_err); end
        n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL timeout_rdata: got %h want 0", rsp_rdata); end
        n_checks++; if (acc_cyc.size() - n0 != 8) begin n_fail++; $display("FAIL timeout_reads: got %0d want 8", acc_cyc.size() - n0); end
        tick();
    endtask
`else
    task automatic test_poll_no_timeout();
        int n0 = acc_cyc.size();
        int seen = 0;
        int t = 0;
        done_config = 1'b0;
        rsp_ready = 1'b1;
        drive_cmd(2'd2, 8'h50, 32'h2, 32'h2); tick();
        cmd_valid = 1'b0;
        repeat (80) begin if (rsp_valid) seen++; tick(); end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL poll_forever_rsp: got %0d responses want 0", seen); end
        n_checks++; if (acc_cyc.size() - n0 <= 8) begin n_fail++; $display("FAIL poll_forever_reads: got %0d want more than 8", acc_cyc.size() - n0); end
        done_config = 1'b1;
        while (!rsp_valid && t < 30) begin tick(); t++; end
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 2'd0) begin n_fail++; $display("FAIL poll_forever_end: got %b/%0d want 1/0", rsp_valid, rsp_err); end
        tick();
        done_config = 1'b0;
    endtask
`endif

    task automatic test_backpressure();
        int accepted = 0;
        int got = 0;
        int t = 0;
        logic [31:0] rd [5];
        logic ready_at [6];
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_cmd(2'd1, 8'(8'h80 + 4 * i), 32'd0, 32'd0);
            ready_at[i] = cmd_ready;
            if (cmd_ready) accepted++;
            tick();
        end
        cmd_valid = 1'b0;
        n_checks++; if (accepted != 5) begin n_fail++; $display("FAIL bp_accepted: got %0d want 5", accepted); end
        n_checks++; if (ready_at[4] !== 1'b1 || ready_at[5] !== 1'b0) begin n_fail++; $display("FAIL bp_ready_drop: got %b%b want 10", ready_at[4], ready_at[5]); end
        repeat (3) tick();
        n_checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL bp_stalled_flags: got ready %b busy %b want 0 1", cmd_ready, busy); end
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hC000_0080) begin n_fail++; $display("FAIL bp_held_rsp: got %b/%h want 1/c0000080", rsp_valid, rsp_rdata); end
        rsp_ready = 1'b1;
        while (got < 5 && t < 60) begin
            if (rsp_valid) begin rd[got] = rsp_rdata; got++; end
            tick(); t++;
        end
        n_checks++; if (got != 5) begin n_fail++; $display("FAIL bp_rsp_count: got %0d want 5", got); end
        for (int i = 0; i < got; i++) begin
            n_checks++; if (rd[i] !== (32'hC000_0080 + 32'(4 * i))) begin n_fail++; $display("FAIL bp_order_%0d: got %h want %h", i, rd[i], 32'hC000_0080 + 32'(4 * i)); end
        end
        repeat (4) tick();
        n_checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got ready %b valid %b want 1 0", cmd_ready, rsp_valid); end
    endtask

    task automatic test_wait_error();
        seq_reg_req_t exp_req;
        int vc = 0;
        int t = 0;
        exp_req = '0;
        exp_req.addr = 32'h84; exp_req.wstrb = 4'hF; exp_req.valid = 1'b1;
        rsp_ready = 1'b1;
        wait_cfg = 3; err_inject = 1'b1;
        drive_cmd(2'd1, 8'h84, 32'd0, 32'd0); tick();
        cmd_valid = 1'b0;
        while (!reg_req.valid && t < 10) begin tick(); t++; end
        t = 0;
        while (reg_req.valid && t < 20) begin
            n_checks++; if (reg_req !== exp_req) begin n_fail++; $display("FAIL wait_req_stable_%0d: got %h want %h", vc, reg_req, exp_req); end
            vc++; tick(); t++;
        end
        n_checks++; if (vc != 4) begin n_fail++; $display("FAIL wait_valid_cycles: got %0d want 4", vc); end
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 2'd1) begin n_fail++; $display("FAIL wait_bus_err: got %b/%0d want 1/1", rsp_valid, rsp_err); end
        tick();
        wait_cfg = 0; err_inject = 1'b0;
        drive_cmd(2'd3, 8'h88, 32'd0, 32'd0); tick();
        cmd_valid = 1'b0;
        t = 0;
        while (!rsp_valid && t < 20) begin tick(); t++; end
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 2'd0 || rsp_rdata !== 32'hC000_0088) begin n_fail++; $display("FAIL after_err_read: got %b/%0d/%h want 1/0/c0000088", rsp_valid, rsp_err, rsp_rdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        int n0;
        int seen = 0;
        int t = 0;
        done_config = 1'b0;
        rsp_ready = 1'b1;
        drive_cmd(2'd2, 8'h50, 32'h2, 32'h2); tick();
        drive_cmd(2'd1, 8'h90, 32'd0, 32'd0); tick();
        drive_cmd(2'd1, 8'h94, 32'd0, 32'd0); tick();
        cmd_valid = 1'b0;
        while (!reg_req.valid && t < 20) begin tick(); t++; end
        n_checks++; if (reg_req.valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_issue: got %b want 1", reg_req.valid); end
        rst_ni = 1'b0;
        #1;
        n_checks++; if (reg_req !== '0) begin n_fail++; $display("FAIL rst_mid_req: got %h want 0", reg_req); end
        n_checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flags: got busy %b ready %b valid %b want 0 1 0", busy, cmd_ready, rsp_valid); end
        tick(); tick();
        rst_ni = 1'b1;
        n0 = acc_cyc.size();
        repeat (30) begin if (rsp_valid) seen++; tick(); end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rst_mid_rsp: got %0d responses want 0", seen); end
        n_checks++; if (acc_cyc.size() != n0) begin n_fail++; $display("FAIL rst_mid_access: got %0d accesses want 0", acc_cyc.size() - n0); end
    endtask

    initial begin
        test_reset();
        test_csr_sequence();
        test_poll();
`ifdef STRELA_SEQ_TIMEOUT_EN
        test_timeout();
`else
        test_poll_no_timeout();
`endif
        test_backpressure();
        test_wait_error();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000 ns, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/strela_reg_sequencer.md
Name: strela_reg_sequencer

Overview:
- Register-interface initiator: drives the CGRA CSR block over the same reg_req_t/reg_rsp_t bus, as the master that issues reads, writes and polls.
- Accepts queued commands (WRITE, READ, POLL) from a local controller or test harness, executes them in order, and returns one response per command.
- Lets a programming sequence run without per-access CPU involvement. An example sequence: set input/output/config addresses, pulse load_configuration, poll done_config, pulse start_execution, poll done_exec_output.

Parameters:
- reg_req_t, logic, register-bus request struct (addr, write, wdata, wstrb, valid).
- reg_rsp_t, logic, register-bus response struct (rdata, error, ready).
- CMD_DEPTH, 4, command FIFO entries; power of two, >= 2.
- POLL_GAP, 4, idle cycles between consecutive poll reads; 0 is legal.
- POLL_MAX_TRIES, 1024, poll attempts before timeout. Used only with the optional feature.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command FIFO not full
- cmd_op_i  in  2  0=WRITE, 1=READ, 2=POLL, 3=reserved (treated as READ)
- cmd_addr_i  in  8  CSR byte address
- cmd_wdata_i  in  32  write data (WRITE) or compare value (POLL)
- cmd_mask_i  in  32  POLL mask; ignored otherwise
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted
- rsp_rdata_o  out  32  read data: last sampled value for READ/POLL, 0 for WRITE
- rsp_err_o  out  2  0=OK, 1=bus error, 2=poll timeout
- busy_o  out  1  FIFO non-empty or FSM not in IDLE
- reg_req_o  out  reg_req_t  bus request to CSR responder
- reg_rsp_i  in  reg_rsp_t  bus response from CSR responder

Behaviour:
- Reset values: all outputs 0 (reg_req_o fields all 0), except cmd_ready_o=1. FIFO is empty and FSM is in IDLE.
- Command handshake:
  - Push on cmd_valid_i & cmd_ready_o.
  - cmd_ready_o = !full, registered from FIFO occupancy.
  - When full, a push is refused even if a pop happens in the same cycle.
- FSM states: IDLE, ISSUE, GAP, RESP.
- IDLE: if FIFO is non-empty, pop the head into the current-command registers and go to ISSUE on the next cycle.
- ISSUE:
  - Drive reg_req_o.valid=1, addr={24'b0,cur_addr}, write=(op==WRITE), wdata=cur_wdata, wstrb=4'hF.
  - Hold all fields stable until reg_rsp_i.ready is seen. The transfer completes in the same cycle as valid & ready.
  - On completion, capture rdata.
    - reg_rsp_i.error set: go to RESP, err=1.
    - WRITE: go to RESP, rdata=0.
    - READ: go to RESP.
    - POLL with (rdata & mask)==(wdata & mask): go to RESP, err=0.
    - POLL otherwise: go to GAP and increment the try counter.
- GAP: count down POLL_GAP cycles, then return to ISSUE. With POLL_GAP=0, go directly to ISSUE (one dead cycle with valid low).
- RESP:
  - rsp_valid_o=1; data and err stay stable until rsp_ready_i.
  - On accept, go to IDLE; the next command is popped the following cycle.
  - Back-pressure on the response stalls the sequencer. The FIFO still accepts pushes while not full.
- Latency with a zero-wait responder (ready tied to 1):
  - push at cycle n, pop at n+1, bus access at n+2, rsp_valid_o at n+3.
  - Back-to-back commands issue one bus access every 3 cycles.
- Only one outstanding bus transfer at a time. reg_req_o.valid is never asserted outside ISSUE.
- The try counter clears when a command is popped.
- Reset mid-operation: an in-flight transfer is abandoned, FIFO contents are discarded, and outputs return to reset values immediately (asynchronous reset).
- FIFO pointers wrap modulo CMD_DEPTH, with a separate count register for full/empty.

Optional Feature:
- Macro: STRELA_SEQ_TIMEOUT_EN.
- Defined:
  - A POLL whose try counter reaches POLL_MAX_TRIES without a match goes to RESP with err=2 and rdata set to the last sampled value.
  - The counter is $clog2(POLL_MAX_TRIES+1) bits wide.
- Undefined:
  - No counter is instantiated; POLL retries indefinitely.
  - err=2 is never produced.

Decomposition:
- Package strela_seq_pkg:
  - seq_op_e (WRITE, READ, POLL).
  - seq_err_e (OK, BUS_ERR, TIMEOUT).
  - seq_state_e (IDLE, ISSUE, GAP, RESP).
  - seq_cmd_t struct {op, addr, wdata, mask}.
- Sub-module strela_seq_cmd_fifo: synchronous FIFO of seq_cmd_t with parameter DEPTH and push/pop/full/empty/count ports.

Test Plan:
- Against the CSR block: WRITE 0x00=5, WRITE 0x04=7, READ 0x08 → three responses; the third has rdata=12, err=0. Each bus access is a single cycle, at 3-cycle spacing.
- POLL addr 0x50, mask 0x2, value 0x2, with done_config_i raised 20 cycles after issue (POLL_GAP=4) → several re-reads 5 cycles apart, then a response with rdata[1]=1, err=0.
- With STRELA_SEQ_TIMEOUT_EN, POLL_MAX_TRIES=8, POLL on 0x50 with done never set → exactly 8 bus reads, then err=2, rdata=0.
- Push 6 commands with rsp_ready_i held low (CMD_DEPTH=4) → cmd_ready_o drops after 4 FIFO pushes plus 1 popped into the FSM. When rsp_ready_i is released, all 5 accepted commands complete in order.
- Responder returning ready=0 for 3 cycles, then error=1 → request fields stable for all 4 cycles, response err=1, and the next command proceeds normally.
- Assert rst_ni low during ISSUE of a POLL with 2 commands queued → reg_req_o.valid drops at once and busy_o=0. After reset, no response appears for the discarded commands.
